gemm_lane_array: RTL
====================

GEMM_LANE_ARRAY -- requirements
Module: gemm_lane_array

Interface
REQ-001 SHALL have parameter LANES, default 8, number of parallel output columns sharing one A operand.
REQ-002 SHALL have parameter A_WIDTH, default 16, signed A operand width.
REQ-003 SHALL have parameter B_WIDTH, default 8, signed B operand width per lane.
REQ-004 SHALL have parameter ACC_WIDTH, default 32, signed accumulator width per lane.
REQ-005 SHALL have parameter OUT_WIDTH, default 16, signed requantized result width per lane.
REQ-006 SHALL have parameter K_MAX, default 256, maximum reduction length; KW = $clog2(K_MAX+1).
REQ-007 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-008 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-009 SHALL have ports: cfg_start  in  1  job start pulse, sampled in ST_IDLE only.
REQ-010 SHALL have ports: cfg_k  in  KW  reduction length; cfg_accum  in  1  keep prior accumulators; cfg_shift  in  $clog2(ACC_WIDTH)  right shift; cfg_sat_en  in  1  saturate enable.
REQ-011 SHALL have ports: in_valid  in  1; in_ready  out  1; a_data  in  A_WIDTH; b_data  in  LANES*B_WIDTH, lane i at bits [i*B_WIDTH +: B_WIDTH].
REQ-012 SHALL have ports: out_valid  out  1; out_ready  in  1; out_data  out  LANES*OUT_WIDTH, same lane packing; out_sat  out  LANES  per-lane clamp flag; busy  out  1  high whenever state != ST_IDLE.

Function
REQ-013 SHALL implement states ST_IDLE, ST_RUN, ST_QUANT, ST_OUT.
REQ-014 SHALL on cfg_start in ST_IDLE latch cfg_k, cfg_shift, cfg_sat_en, load k counter to 0, clear all accumulators unless cfg_accum=1, and enter ST_RUN (cfg_k>0) or ST_QUANT (cfg_k=0).
REQ-015 SHALL ignore cfg_start and cfg_* changes outside ST_IDLE.
REQ-016 SHALL drive in_ready=1 only in ST_RUN; a beat transfers when in_valid && in_ready.
REQ-017 SHALL per transferred beat add signed(a_data)*signed(b_data[i]), sign-extended to ACC_WIDTH, into lane i accumulator, wrapping modulo 2^ACC_WIDTH.
REQ-018 SHALL leave accumulators and counter unchanged on RUN cycles without a transfer.
REQ-019 SHALL move to ST_QUANT on the transfer of beat number latched_k (counter == latched_k-1).
REQ-020 SHALL in ST_QUANT compute per lane r = (acc + (shift>0 ? 2^(shift-1) : 0)) >>> shift in ACC_WIDTH+1 bits (round half up), register it, then enter ST_OUT with out_valid=1 next cycle.
REQ-021 SHALL when latched sat_en=1 clamp r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and set out_sat[i] if clamped; when 0 take the low OUT_WIDTH bits and hold out_sat[i]=0.
REQ-022 SHALL hold out_data/out_sat stable while out_valid=1 and out_ready=0.
REQ-023 SHALL on out_valid && out_ready drop out_valid and return to ST_IDLE; accumulators retain values for a later cfg_accum=1 job.
REQ-024 SHALL give latency of exactly 2 cycles from the clock edge of the last input transfer to out_valid=1.
REQ-025 SHALL accept a new cfg_start in the cycle immediately after the output transfer (ST_IDLE); no back-to-back overlap.

Reset
REQ-026 SHALL on rst=1, at any time including mid-job, immediately force state=ST_IDLE, all accumulators=0, k counter=0, out_valid=0, out_data=0, out_sat=0, busy=0, in_ready=0, latched cfg=0.
REQ-027 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Structure
REQ-028 SHALL place state_t enum and shared width helper constants in package gemm_pkg.
REQ-029 SHALL implement per-lane round/shift/saturate as sub-module gemm_requant, instantiated LANES times by generate.
REQ-030 SHALL use one always_ff process sensitive to posedge clk or posedge rst for all state.

Verification
REQ-031 Bench: cfg_k=4, shift=0, sat off, a=2, b lane i = i+1 for 4 beats -> out lane i = 8*(i+1), out_valid 2 cycles after 4th beat.
REQ-032 Bench: cfg_k=3 with in_valid toggled 1,0,1,0,1 and out_ready low 5 cycles -> same results as gapless, out_data stable while stalled.
REQ-033 Bench: a=-32768, b=127, cfg_k=2, shift=0, sat on -> lane = -32768 with out_sat=1; sat off -> low 16 bits of -8323072 (0x0000), out_sat=0.
REQ-034 Bench: acc=7, shift=1 -> 4; acc=-7, shift=1 -> -3 (round half up).
REQ-035 Bench: job cfg_k=2 results X, then cfg_accum=1 cfg_k=2 same data -> 2X; cfg_k=0 with cfg_accum=0 -> all zero outputs after 2 cycles.
REQ-036 Bench: assert rst during ST_RUN after 2 of 4 beats -> in_ready, busy, out_valid low next cycle; fresh job yields uncontaminated result.

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared types and default sizing for the GEMM lane array and its requantizer.
package gemm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_QUANT = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    localparam int DEF_LANES     = 8;
    localparam int DEF_A_WIDTH   = 16;
    localparam int DEF_B_WIDTH   = 8;
    localparam int DEF_ACC_WIDTH = 32;
    localparam int DEF_OUT_WIDTH = 16;
    localparam int DEF_K_MAX     = 256;

    // Full-precision width of one signed A*B product.
    function automatic int prod_width(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

endpackage

// File: rtl/gemm_requant.sv
// Per-lane requantizer: round-half-up arithmetic right shift, then optional
// saturation to the signed output range.
module gemm_requant
    import gemm_pkg::*;
#(
    parameter  int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter  int OUT_WIDTH = DEF_OUT_WIDTH,
    localparam int SW        = $clog2(ACC_WIDTH)
) (
    input  logic signed [ACC_WIDTH-1:0] acc_i,
    input  logic        [SW-1:0]        shift_i,
    input  logic                        sat_en_i,
    output logic        [OUT_WIDTH-1:0] data_o,
    output logic                        sat_o
);
    // One extra bit so the rounding bias can never overflow the accumulator.
    localparam int EW = ACC_WIDTH + 1;
    localparam logic signed [EW-1:0] OUT_MAX = {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] OUT_MIN = {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] bias;
    logic signed [EW-1:0] shifted;

    // NOTE: combinational logic uses blocking assignments, and every output gets
    // a default at the top of the block so no latch can be inferred.
    always_comb begin
        ext     = {acc_i[ACC_WIDTH-1], acc_i};
        bias    = (shift_i != '0) ? (EW'(1) << (shift_i - SW'(1))) : '0;
        shifted = (ext + bias) >>> shift_i;
        data_o  = shifted[OUT_WIDTH-1:0];
        sat_o   = 1'b0;
        if (sat_en_i) begin
            if (shifted > OUT_MAX) begin
                data_o = OUT_MAX[OUT_WIDTH-1:0];
                sat_o  = 1'b1;
            end else if (shifted < OUT_MIN) begin
                data_o = OUT_MIN[OUT_WIDTH-1:0];
                sat_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gemm_lane_array.sv
// LANES-wide multiply-accumulate array sharing one A operand per beat, with a
// requantize stage and a valid/ready result port.
module gemm_lane_array
    import gemm_pkg::*;
#(
    parameter  int LANES     = DEF_LANES,
    parameter  int A_WIDTH   = DEF_A_WIDTH,
    parameter  int B_WIDTH   = DEF_B_WIDTH,
    parameter  int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter  int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter  int K_MAX     = DEF_K_MAX,
    localparam int KW        = $clog2(K_MAX + 1),
    localparam int SW        = $clog2(ACC_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_start,
    input  logic [KW-1:0]                cfg_k,
    input  logic                         cfg_accum,
    input  logic [SW-1:0]                cfg_shift,
    input  logic                         cfg_sat_en,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [A_WIDTH-1:0]           a_data,
    input  logic [LANES*B_WIDTH-1:0]     b_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*OUT_WIDTH-1:0]   out_data,
    output logic [LANES-1:0]             out_sat,
    output logic                         busy
);
    localparam int PW = prod_width(A_WIDTH, B_WIDTH);

    state_t                      state_q;
    logic [KW-1:0]               k_q;
    logic [KW-1:0]               cnt_q;
    logic [SW-1:0]               shift_q;
    logic                        sat_en_q;
    logic                        in_ready_q;
    logic                        busy_q;
    logic                        out_valid_q;
    logic [LANES*OUT_WIDTH-1:0]  out_data_q;
    logic [LANES-1:0]            out_sat_q;
    logic signed [ACC_WIDTH-1:0] acc_q [LANES];
    logic signed [ACC_WIDTH-1:0] acc_d [LANES];
    logic [LANES*OUT_WIDTH-1:0]  quant_data;
    logic [LANES-1:0]            quant_sat;
    logic                        beat;
    logic                        last_beat;

    assign beat      = in_valid && in_ready_q;
    assign last_beat = (cnt_q == k_q - KW'(1));

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [B_WIDTH-1:0] b_lane;
        logic signed [PW-1:0]      prod;

        assign b_lane   = b_data[i*B_WIDTH +: B_WIDTH];
        assign prod     = PW'($signed(a_data)) * PW'(b_lane);
        assign acc_d[i] = acc_q[i] + ACC_WIDTH'(prod);

        gemm_requant #(
            .ACC_WIDTH (ACC_WIDTH),
            .OUT_WIDTH (OUT_WIDTH)
        ) u_requant (
            .acc_i    (acc_q[i]),
            .shift_i  (shift_q),
            .sat_en_i (sat_en_q),
            .data_o   (quant_data[i*OUT_WIDTH +: OUT_WIDTH]),
            .sat_o    (quant_sat[i])
        );
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            cnt_q       <= '0;
            shift_q     <= '0;
            sat_en_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= '0;
            // NOTE: the accumulator bank is reset, unlike a plain memory, because a
            // cfg_accum job after reset must start from zero.
            for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_start) begin
                        k_q        <= cfg_k;
                        shift_q    <= cfg_shift;
                        sat_en_q   <= cfg_sat_en;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        in_ready_q <= (cfg_k != '0);
                        state_q    <= (cfg_k == '0) ? ST_QUANT : ST_RUN;
                        if (!cfg_accum) begin
                            for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (beat) begin
                        for (int i = 0; i < LANES; i++) acc_q[i] <= acc_d[i];
                        cnt_q <= cnt_q + KW'(1);
                        if (last_beat) begin
                            in_ready_q <= 1'b0;
                            state_q    <= ST_QUANT;
                        end
                    end
                end
                ST_QUANT: begin
                    out_data_q <= quant_data;
                    out_sat_q  <= quant_sat;
                    state_q    <= ST_OUT;
                end
                ST_OUT: begin
                    // First ST_OUT cycle raises valid; the result is already registered.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule
